// File: rtl/cursor_input_ctrl_pkg.sv
// Shared encodings for the cursor/house input path: house codes, direction
// bit positions inside btn_dir, and the auto-repeat state type.
package hp_input_pkg;

  localparam logic [1:0] HOUSE_G = 2'd0;
  localparam logic [1:0] HOUSE_S = 2'd1;
  localparam logic [1:0] HOUSE_H = 2'd2;
  localparam logic [1:0] HOUSE_R = 2'd3;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  // Pressed-house vector is ordered G,S,H,R from bit 3 down; G wins ties.
  function automatic logic [1:0] house_encode(input logic [3:0] pressed);
    if (pressed[3])      return HOUSE_G;
    else if (pressed[2]) return HOUSE_S;
    else if (pressed[1]) return HOUSE_H;
    else                 return HOUSE_R;
  endfunction

endpackage

// File: rtl/cursor_input_ctrl_if.sv
// Board-pin and display-side signals of the cursor input conditioner.
interface cursor_input_ctrl_if #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  logic [3:0]    btn_dir;
  logic [3:0]    btn_house;
  logic          frame_start;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic [1:0]    house;
  logic          house_valid;
  logic          move_pulse;

  modport master (
    output btn_dir, btn_house, frame_start,
    input  cursor_x, cursor_y, house, house_valid, move_pulse
  );

  modport slave (
    input  btn_dir, btn_house, frame_start,
    output cursor_x, cursor_y, house, house_valid, move_pulse
  );
endinterface

// File: rtl/cursor_input_ctrl_btn_debounce.sv
// One push-button: polarity fix, 2-flop synchroniser, stable-count debouncer
// and a one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clock,
  input  logic resetn,
  input  logic pin,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

  logic          pin_active;
  logic [1:0]    sync_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  // Inverting before the flops keeps the all-zero reset state "not pressed".
  assign pin_active = ACTIVE_LOW ? ~pin : pin;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], pin_active};
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        level_reg <= sync_reg[1];
        press_reg <= sync_reg[1];
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;
endmodule

// File: rtl/cursor_input_ctrl.sv
// Cursor/house input conditioner: debounced buttons, per-direction auto-repeat,
// clamped target position copied to the display at frame start, house latch.
module cursor_input_ctrl
  import hp_input_pkg::*;
#(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int CUR_W          = 16,
  parameter int CUR_H          = 16,
  parameter int STEP           = 4,
  parameter int DEBOUNCE_CYC   = 500000,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_PERIOD  = 5000000,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic                clock,
  input  logic                resetn,
  cursor_input_ctrl_if.slave  bus
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [XW:0] X_MAX  = (XW+1)'(H_RES - CUR_W);
  localparam logic [YW:0] Y_MAX  = (YW+1)'(V_RES - CUR_H);
  localparam logic [XW:0] X_INIT = (XW+1)'((H_RES - CUR_W) / 2);
  localparam logic [YW:0] Y_INIT = (YW+1)'((V_RES - CUR_H) / 2);
  localparam logic [XW:0] STEP_X = (XW+1)'(STEP);
  localparam logic [YW:0] STEP_Y = (YW+1)'(STEP);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD);

  logic [7:0] pins, db_level, db_press;
  logic [3:0] dir_level, dir_press, dir_step, house_evt;

  assign pins = {bus.btn_dir, bus.btn_house};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_db
      btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .ACTIVE_LOW   (BTN_ACTIVE_LOW != 0)
      ) u_db (
        .clock  (clock),
        .resetn (resetn),
        .pin    (pins[gi]),
        .level  (db_level[gi]),
        .press  (db_press[gi])
      );
    end
  endgenerate

  assign dir_level = db_level[7:4];
  assign dir_press = db_press[7:4];
  assign house_evt = db_press[3:0] & db_level[3:0];

  // Counter restarts at 1 on every step, so a step fires exactly N cycles later.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rpt
      rpt_state_t    state_reg, state_next;
      logic [RW-1:0] cnt_reg, cnt_next;
      logic          step_c;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          state_reg <= RPT_IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        step_c     = 1'b0;
        case (state_reg)
          RPT_IDLE: begin
            cnt_next = '0;
            if (dir_press[gi]) begin
              state_next = RPT_DELAY;
              cnt_next   = RW'(1);
              step_c     = 1'b1;
            end
          end
          RPT_DELAY: begin
            if (!dir_level[gi]) begin
              state_next = RPT_IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == DELAY_MAX) begin
              state_next = RPT_REPEAT;
              cnt_next   = RW'(1);
              step_c     = 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (!dir_level[gi]) begin
              state_next = RPT_IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == PERIOD_MAX) begin
              cnt_next = RW'(1);
              step_c   = 1'b1;
            end
          end
          default: begin
            state_next = RPT_IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      assign dir_step[gi] = step_c;
    end
  endgenerate

  logic [XW:0]   tx_reg, tx_next, tx_inc, tx_dec;
  logic [YW:0]   ty_reg, ty_next, ty_inc, ty_dec;
  logic [XW-1:0] cursor_x_reg;
  logic [YW-1:0] cursor_y_reg;
  logic [1:0]    house_reg;
  logic          house_valid_reg, move_pulse_reg;

  // One spare bit: a decrement below zero shows up in the top bit.
  always_comb begin
    tx_inc  = tx_reg + STEP_X;
    tx_dec  = tx_reg - STEP_X;
    ty_inc  = ty_reg + STEP_Y;
    ty_dec  = ty_reg - STEP_Y;
    tx_next = tx_reg;
    ty_next = ty_reg;
    if (dir_step[DIR_RIGHT] && !dir_step[DIR_LEFT])
      tx_next = (tx_inc > X_MAX) ? X_MAX : tx_inc;
    else if (dir_step[DIR_LEFT] && !dir_step[DIR_RIGHT])
      tx_next = tx_dec[XW] ? '0 : tx_dec;
    if (dir_step[DIR_DOWN] && !dir_step[DIR_UP])
      ty_next = (ty_inc > Y_MAX) ? Y_MAX : ty_inc;
    else if (dir_step[DIR_UP] && !dir_step[DIR_DOWN])
      ty_next = ty_dec[YW] ? '0 : ty_dec;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_reg          <= X_INIT;
      ty_reg          <= Y_INIT;
      cursor_x_reg    <= X_INIT[XW-1:0];
      cursor_y_reg    <= Y_INIT[YW-1:0];
      move_pulse_reg  <= 1'b0;
      house_reg       <= HOUSE_G;
      house_valid_reg <= 1'b0;
    end else begin
      tx_reg         <= tx_next;
      ty_reg         <= ty_next;
      move_pulse_reg <= (tx_next != tx_reg) || (ty_next != ty_reg);
      // Copies the pre-step target; a coincident step appears next frame.
      if (bus.frame_start) begin
        cursor_x_reg <= tx_reg[XW-1:0];
        cursor_y_reg <= ty_reg[YW-1:0];
      end
      if (|house_evt) begin
        house_reg       <= house_encode(house_evt);
        house_valid_reg <= 1'b1;
      end
    end
  end

  assign bus.cursor_x    = cursor_x_reg;
  assign bus.cursor_y    = cursor_y_reg;
  assign bus.house       = house_reg;
  assign bus.house_valid = house_valid_reg;
  assign bus.move_pulse  = move_pulse_reg;
endmodule

// File: tb/tb_cursor_input_ctrl.sv
// Directed bench for cursor_input_ctrl with short debounce/repeat timings.
module tb_cursor_input_ctrl;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  cursor_input_ctrl_if #(.H_RES(640), .V_RES(480)) bus();

  cursor_input_ctrl #(
    .H_RES(640), .V_RES(480), .CUR_W(16), .CUR_H(16), .STEP(4),
    .DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  int p0;
  int quiet;

  always @(posedge clock) if (bus.move_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Active-low pins: 0 = pressed. Tail wait lets the release debounce out.
  task automatic press_dir(input int idx, input int hold);
    bus.btn_dir[idx] = 1'b0;
    cycles(hold);
    bus.btn_dir[idx] = 1'b1;
    cycles(12);
  endtask

  task automatic show_frame();
    bus.frame_start = 1'b1;
    cycles(1);
    bus.frame_start = 1'b0;
    cycles(1);
  endtask

  initial begin
    bus.btn_dir = 4'hF;
    bus.btn_house = 4'hF;
    bus.frame_start = 1'b0;
    cycles(3);
    check_val("rst_x", bus.cursor_x, 312);
    check_val("rst_y", bus.cursor_y, 232);
    check_val("rst_house", bus.house, 0);
    check_val("rst_valid", bus.house_valid, 0);
    check_val("rst_pulse", bus.move_pulse, 0);
    resetn = 1'b1;
    cycles(2);

    // single right step
    p0 = pulse_cnt;
    press_dir(0, 10);
    check_val("step_pulses", pulse_cnt - p0, 1);
    show_frame();
    check_val("step_x", bus.cursor_x, 316);
    check_val("step_y", bus.cursor_y, 232);

    // bounce on up, 2-cycle toggles
    p0 = pulse_cnt;
    for (int i = 0; i < 15; i++) begin
      bus.btn_dir[3] = ~bus.btn_dir[3];
      cycles(2);
    end
    bus.btn_dir[3] = 1'b1;
    cycles(12);
    check_val("bounce_pulses", pulse_cnt - p0, 0);
    show_frame();
    check_val("bounce_x", bus.cursor_x, 316);
    check_val("bounce_y", bus.cursor_y, 232);

    // auto-repeat left: debounced level high 53 cycles -> steps at 0,20..50
    p0 = pulse_cnt;
    press_dir(1, 53);
    check_val("rpt_pulses", pulse_cnt - p0, 8);
    show_frame();
    check_val("rpt_x", bus.cursor_x, 284);

    // clamp at x=0 and y=464
    press_dir(1, 500);
    p0 = pulse_cnt;
    press_dir(1, 10);
    check_val("clampx_pulses", pulse_cnt - p0, 0);
    show_frame();
    check_val("clampx_x", bus.cursor_x, 0);
    press_dir(2, 500);
    p0 = pulse_cnt;
    press_dir(2, 10);
    check_val("clampy_pulses", pulse_cnt - p0, 0);
    show_frame();
    check_val("clampy_y", bus.cursor_y, 464);

    // up+down together cancel
    p0 = pulse_cnt;
    bus.btn_dir[3] = 1'b0;
    bus.btn_dir[2] = 1'b0;
    cycles(10);
    bus.btn_dir[3] = 1'b1;
    bus.btn_dir[2] = 1'b1;
    cycles(12);
    check_val("updown_pulses", pulse_cnt - p0, 0);
    show_frame();
    check_val("updown_y", bus.cursor_y, 464);

    // S and R together -> S
    bus.btn_house = 4'b1010;
    cycles(10);
    bus.btn_house = 4'hF;
    cycles(12);
    check_val("sr_house", bus.house, 1);
    check_val("sr_valid", bus.house_valid, 1);

    // right step lands in the same cycle as frame_start
    bus.btn_dir[0] = 1'b0;
    cycles(7);
    bus.frame_start = 1'b1;
    cycles(1);
    bus.frame_start = 1'b0;
    check_val("coin_x", bus.cursor_x, 0);
    check_val("coin_pulse", bus.move_pulse, 1);
    cycles(2);
    bus.btn_dir[0] = 1'b1;
    cycles(12);
    show_frame();
    check_val("coin_next_x", bus.cursor_x, 4);

    // select H, then reset while left is in REPEAT
    bus.btn_house[1] = 1'b0;
    cycles(10);
    bus.btn_house[1] = 1'b1;
    cycles(12);
    check_val("h_house", bus.house, 2);
    bus.btn_dir[1] = 1'b0;
    cycles(40);
    resetn = 1'b0;
    #1;
    check_val("mid_rst_x", bus.cursor_x, 312);
    check_val("mid_rst_y", bus.cursor_y, 232);
    check_val("mid_rst_house", bus.house, 0);
    check_val("mid_rst_valid", bus.house_valid, 0);
    check_val("mid_rst_pulse", bus.move_pulse, 0);
    cycles(1);
    resetn = 1'b1;
    quiet = 0;
    for (int i = 0; i < 7; i++) begin
      cycles(1);
      if (bus.move_pulse) quiet++;
    end
    check_val("post_rst_quiet", quiet, 0);
    cycles(1);
    check_val("post_rst_pulse", bus.move_pulse, 1);
    bus.btn_dir[1] = 1'b1;
    cycles(12);
    show_frame();
    check_val("post_rst_x", bus.cursor_x, 308);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
